// File: rtl/mult_pkg.sv
// Shared types and defaults for the shared
// shift-add multiplier scheduler.
package mult_pkg;

  localparam int BIT_LEN_DEF = 4;
  localparam int NUM_REQ_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier core:
// one partial product per step, BIT_LEN steps.
module shift_add_mul
  import mult_pkg::*;
#(
  parameter int BIT_LEN = BIT_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   step,
  input  logic [BIT_LEN-1:0]     a,
  input  logic [BIT_LEN-1:0]     b,
  output logic                   done,
  output logic [2*BIT_LEN-1:0]   acc
);

  localparam int CW = $clog2(BIT_LEN) + 1;

  logic [2*BIT_LEN-1:0] mcand;
  logic [BIT_LEN-1:0]   mplier;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{BIT_LEN{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // high during the final step, so the FSM leaves RUN on that edge
  assign done = (cnt == CW'(BIT_LEN - 1));

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one shift-add
// multiplier among NUM_REQ requesters.
module mult_sched
  import mult_pkg::*;
#(
  parameter int BIT_LEN = BIT_LEN_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_a,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [2*BIT_LEN-1:0]       rsp_product,
  output logic                       busy
);

  localparam int IW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state;
  state_t               state_n;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 start;
  logic                 step;
  logic                 done;
  logic [BIT_LEN-1:0]   a_sel;
  logic [BIT_LEN-1:0]   b_sel;
  logic [2*BIT_LEN-1:0] acc;
  logic [2*BIT_LEN-1:0] prod_q;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  assign a_sel = req_a[gnt_idx*BIT_LEN +: BIT_LEN];
  assign b_sel = req_b[gnt_idx*BIT_LEN +: BIT_LEN];

  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          start   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (done) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      prod_q     <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        last_grant <= gnt_idx;
        owner      <= gnt_idx;
      end
      if (state == DONE) begin
        prod_q <= acc;
      end
    end
  end

  shift_add_mul #(
    .BIT_LEN (BIT_LEN)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .step  (step),
    .a     (a_sel),
    .b     (b_sel),
    .done  (done),
    .acc   (acc)
  );

  // grant is gated by rst_n so nothing handshakes while held in reset
  assign req_ready =
    (rst_n && state == IDLE && gnt_any)
      ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign rsp_valid =
    (state == DONE) ? (NUM_REQ'(1) << owner) : '0;

  assign rsp_product =
    (state == DONE) ? acc : prod_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with
// BIT_LEN=4, NUM_REQ=2.
module tb_mult_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_product;
  logic       busy;

  int errs;
  int checks;
  int cyc;

  typedef struct {
    int         who;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  mult_sched #(
    .BIT_LEN (4),
    .NUM_REQ (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int w,
                         input logic [3:0] a,
                         input logic [3:0] b);
    req_valid[w]     = 1'b1;
    req_a[w*4 +: 4]  = a;
    req_b[w*4 +: 4]  = b;
  endtask

  // returns just after the handshake edge; c is the
  // cycle count sampled before that edge
  task automatic wait_hs(input string nm,
                         input int w,
                         output int c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[w]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) chk({nm, "_ready"}, 32'(req_ready), 32'(oh(w)));
    else    chk({nm, "_hs_timeout"}, 0, 1);
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  // latency is the edge count from handshake to the
  // edge that consumes the rsp_valid pulse
  task automatic wait_rsp(input string nm,
                          input int c_hs,
                          input logic [1:0] own,
                          input logic [7:0] p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({nm, "_rsp_timeout"}, 0, 1);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - c_hs), 5);
      chk({nm, "_own"}, 32'(rsp_valid), 32'(own));
      chk({nm, "_prod"}, 32'(rsp_product), 32'(p));
      @(negedge clk);
      chk({nm, "_drop"}, 32'(rsp_valid), 0);
      chk({nm, "_hold"}, 32'(rsp_product), 32'(p));
      chk({nm, "_idle"}, 32'(busy), 0);
    end
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int c;
    @(negedge clk);
    set_req(v.who, v.a, v.b);
    wait_hs(nm, v.who, c);
    req_valid = 2'b00;
    chk({nm, "_busy"}, 32'(busy), 1);
    wait_rsp(nm, c, oh(v.who), v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    int  c1;
    bit  any;
    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = 8'h57;
    req_b     = 8'h63;

    vecs[0] = '{0, 4'd0,  4'd0,  8'h00};
    vecs[1] = '{0, 4'd1,  4'd1,  8'h01};
    vecs[2] = '{0, 4'd15, 4'd15, 8'hE1};
    vecs[3] = '{0, 4'd13, 4'd11, 8'h8F};
    vecs[4] = '{1, 4'd9,  4'd7,  8'h3F};
    vecs[5] = '{1, 4'd0,  4'd15, 8'h00};
    vecs[6] = '{1, 4'd15, 4'd1,  8'h0F};
    vecs[7] = '{0, 4'd8,  4'd8,  8'h40};

    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_prod", 32'(rsp_product), 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // simultaneous requests: req0 then req1, 6 edges apart
    @(negedge clk);
    set_req(0, 4'd7, 4'd3);
    set_req(1, 4'd5, 4'd6);
    wait_hs("both0", 0, c0);
    req_valid[0] = 1'b0;
    wait_rsp("both0", c0, 2'b01, 8'h15);
    wait_hs("both1", 1, c1);
    req_valid = 2'b00;
    chk("both_space", 32'(c1 - c0), 6);
    wait_rsp("both1", c1, 2'b10, 8'h1E);

    // both held continuously: grants alternate
    @(negedge clk);
    set_req(0, 4'd2, 4'd3);
    set_req(1, 4'd4, 4'd5);
    for (int k = 0; k < 4; k++) begin
      wait_hs($sformatf("rr%0d", k), k % 2, c0);
      if (k == 3) req_valid = 2'b00;
      wait_rsp($sformatf("rr%0d", k), c0, oh(k % 2),
               (k % 2 == 0) ? 8'h06 : 8'h14);
    end

    // request raised mid-RUN waits for the IDLE cycle
    @(negedge clk);
    set_req(0, 4'd6, 4'd7);
    wait_hs("late0", 0, c0);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 4'd3, 4'd5);
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready != 2'b00) any = 1'b1;
      if (rsp_valid != 2'b00) break;
      @(negedge clk);
    end
    chk("late_noready", 32'(any), 0);
    chk("late0_prod", 32'(rsp_product), 32'h2A);
    @(negedge clk);
    wait_hs("late1", 1, c1);
    req_valid = 2'b00;
    chk("late_space", 32'(c1 - c0), 6);
    wait_rsp("late1", c1, 2'b10, 8'h0F);

    // reset two edges into RUN aborts the op
    @(negedge clk);
    set_req(0, 4'd9, 4'd9);
    wait_hs("abort", 0, c0);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("abort_ready", 32'(req_ready), 0);
    chk("abort_rspv", 32'(rsp_valid), 0);
    chk("abort_prod", 32'(rsp_product), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) any = 1'b1;
    end
    chk("abort_norsp", 32'(any), 0);

    // round-robin pointer restarted: req0 would win
    set_req(0, 4'd1, 4'd1);
    set_req(1, 4'd3, 4'd4);
    #1;
    chk("restart_rr", 32'(req_ready), 32'(2'b01));
    req_valid[0] = 1'b0;
    wait_hs("post", 1, c1);
    req_valid = 2'b00;
    wait_rsp("post", c1, 2'b10, 8'h0C);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter BIT_LEN, default 4: operand width in bits.
REQ-002 Parameter NUM_REQ, default 2: number of requesters sharing one shift-add multiplier.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_a  input  NUM_REQ*BIT_LEN  packed factor1 per requester; slice i belongs to requester i.
REQ-007 req_b  input  NUM_REQ*BIT_LEN  packed factor2 per requester.
REQ-008 req_ready  output  NUM_REQ  one-hot accept; handshake on the edge where req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking the product owner.
REQ-010 rsp_product  output  2*BIT_LEN  unsigned product; meaningful only while rsp_valid is nonzero.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 States: IDLE, RUN, DONE; at most one operation in flight.
REQ-013 IDLE: grant the first asserted req_valid in round-robin order starting at last_grant+1 (mod NUM_REQ); req_ready carries that grant combinationally; with no valid request, req_ready is all zero.
REQ-014 req_ready is zero in RUN and DONE.
REQ-015 Handshake edge: capture the winner's req_a/req_b slices and index, clear accumulator and bit counter, set last_grant to the winner, go to RUN.
REQ-016 RUN: one shift-add iteration per edge (add shifted multiplicand when current multiplier bit is 1); after exactly BIT_LEN RUN edges go to DONE.
REQ-017 Latency is fixed: rsp_valid asserts exactly BIT_LEN+1 edges after the handshake edge, independent of operand values (zero operands included).
REQ-018 DONE: rsp_valid[owner]=1 and rsp_product=a*b for one cycle; next edge returns to IDLE; no response backpressure.
REQ-019 Arithmetic: unsigned, exact, 2*BIT_LEN bits, no truncation; max (2^BIT_LEN-1)^2 fits.
REQ-020 rsp_product holds its last value outside DONE; rsp_valid is zero outside DONE.
REQ-021 Requester holds req_valid and operands stable until accepted; changing operands before acceptance is the requester's error, and the block samples only at the handshake edge.
REQ-022 Requests raised during RUN/DONE wait; earliest acceptance is the IDLE cycle after DONE; back-to-back spacing is BIT_LEN+2 edges.
REQ-023 Simultaneous requests: exactly one granted per IDLE cycle; others see req_ready=0.

Reset
REQ-024 rst_n low: state=IDLE, last_grant=NUM_REQ-1 (requester 0 first), accumulator/counter/operands=0, rsp_product=0, rsp_valid=0, busy=0, req_ready forced 0 while rst_n low.
REQ-025 Reset during RUN or DONE aborts the operation; no rsp_valid is produced for it.

Structure
REQ-026 Package mult_pkg holds the state enum typedef and the default BIT_LEN/NUM_REQ constants.
REQ-027 One sub-module, shift_add_mul: operand registers, accumulator, bit counter, start/done; mult_sched holds the FSM, arbiter and response muxing.

Verification (BIT_LEN=4, NUM_REQ=2)
REQ-028 Reset: rst_n low mid-stimulus -> all outputs 0, busy 0, req_ready 00.
REQ-029 Single requester 0: 0x0, 1x1, 15x15 -> rsp_valid=01 exactly 5 edges after each handshake, products 0x00, 0x01, 0xE1.
REQ-030 Both valid same cycle, req0 7x3, req1 5x6 -> req0 granted first (0x15), then req1 (0x1E); handshakes 6 edges apart.
REQ-031 Both held valid continuously for 4 ops -> grant order 0,1,0,1; no starvation.
REQ-032 rst_n pulsed 2 edges into RUN -> no rsp_valid; after release, req1 alone 3x4 -> accepted, 0x0C, last_grant restarted.
REQ-033 req1 raised during RUN -> req_ready stays 0 until IDLE, accepted on first IDLE edge, correct product.
